// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Pipeline hazard / control unit for a Y86-style 5-stage pipeline.
//   Detects load/use, branch mispredict, ret-in-flight and exception
//   conditions. It produces the stall and bubble controls for the pipeline
//   registers and the condition-code write enable. It also keeps saturating
//   performance counters for stalls, bubbles and mispredicts.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   D_icode, E_icode, M_icode    instruction codes in the D, E and M stages
//   d_srcA, d_srcB               decode source register IDs
//   E_dstM                       E-stage memory destination register ID
//   e_cnd                        E-stage condition outcome
//   m_stat, W_stat               M and W stage status (AOK = MSB only)
//   count_clr                    synchronous clear of all counters
//   F_stall, D_stall, D_bubble,
//   E_bubble, W_stall            pipeline register controls
//   set_cc                       condition-code write enable
//   halted                       high while in HALT
//   state                        RUN=0, LU_WAIT=1, HALT=2
//   stall_cnt, bubble_cnt,
//   mispred_cnt                  saturating performance counters
module pipe_hazard_unit #(
  parameter int unsigned      REG_W    = 4,
  parameter int unsigned      STAT_W   = 4,
  parameter int unsigned      CNT_W    = 16,
  parameter int unsigned      LU_STALL = 1,
  parameter logic [REG_W-1:0] RNONE    = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        M_icode,
  input  logic [REG_W-1:0]  d_srcA,
  input  logic [REG_W-1:0]  d_srcB,
  input  logic [REG_W-1:0]  E_dstM,
  input  logic              e_cnd,
  input  logic [STAT_W-1:0] m_stat,
  input  logic [STAT_W-1:0] W_stat,
  input  logic              count_clr,
  output logic              F_stall,
  output logic              D_stall,
  output logic              D_bubble,
  output logic              E_bubble,
  output logic              W_stall,
  output logic              set_cc,
  output logic              halted,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam logic [STAT_W-1:0] AOK = {1'b1, {(STAT_W-1){1'b0}}};

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] LU_WAIT = 2'd1;
  localparam logic [1:0] HALT    = 2'd2;

  localparam logic [1:0] LU_INIT = 2'(LU_STALL - 1);

  logic       exc, mispred, load_use, ret_flight;
  logic       mispred_ev;
  logic [1:0] lu_cnt, lu_cnt_nxt;
  logic [1:0] state_nxt;

  assign exc        = (W_stat != AOK);
  assign mispred    = (E_icode == 4'h7) && !e_cnd;
  assign ret_flight = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
  // A source of RNONE can never match because E_dstM is already required
  // to differ from RNONE.
  assign load_use   = ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != RNONE) &&
                      (((d_srcA != RNONE) && (E_dstM == d_srcA)) ||
                       ((d_srcB != RNONE) && (E_dstM == d_srcB)));

  always_comb begin
    F_stall    = 1'b0;
    D_stall    = 1'b0;
    D_bubble   = 1'b0;
    E_bubble   = 1'b0;
    W_stall    = 1'b0;
    halted     = 1'b0;
    mispred_ev = 1'b0;
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    case (state)
      RUN: begin
        if (exc) begin
          {F_stall, D_stall, E_bubble, W_stall} = '1;
          state_nxt = HALT;
        end else if (mispred) begin
          D_bubble   = 1'b1;
          E_bubble   = 1'b1;
          mispred_ev = 1'b1;
        end else if (load_use) begin
          {F_stall, D_stall, E_bubble} = '1;
          if (LU_STALL > 1) begin
            state_nxt  = LU_WAIT;
            lu_cnt_nxt = LU_INIT;
          end
        end else if (ret_flight) begin
          F_stall  = 1'b1;
          D_bubble = 1'b1;
        end
      end
      LU_WAIT: begin
        if (exc) begin
          {F_stall, D_stall, E_bubble, W_stall} = '1;
          state_nxt  = HALT;
          lu_cnt_nxt = '0;
        end else begin
          {F_stall, D_stall, E_bubble} = '1;
          lu_cnt_nxt = (lu_cnt > 2'd1) ? lu_cnt - 2'd1 : '0;
          if (lu_cnt <= 2'd1) state_nxt = RUN;
        end
      end
      HALT: begin
        {F_stall, D_stall, E_bubble, W_stall, halted} = '1;
      end
      default: begin
        state_nxt  = RUN;
        lu_cnt_nxt = '0;
      end
    endcase
    if (rst) begin
      {F_stall, D_stall, D_bubble, E_bubble, W_stall, halted, mispred_ev} = '0;
    end
  end

  assign set_cc = !rst && (state != HALT) && (E_icode != 4'h0) &&
                  (m_stat == AOK) && (W_stat == AOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (count_clr) begin
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (state != HALT) begin
      if (F_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((D_bubble || E_bubble) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (mispred_ev && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit
//   Randomized and directed checks of pipe_hazard_unit (LU_STALL=2, CNT_W=4)
//   against a behavioural model that tracks halted / remaining-stall cycles.
module tb_pipe_hazard_unit;

  localparam int LU  = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    D_icode = 4'h1, E_icode = 4'h1, M_icode = 4'h1;
  logic [3:0]    d_srcA = 4'hF, d_srcB = 4'hF, E_dstM = 4'hF;
  logic          e_cnd = 1'b1;
  logic [3:0]    m_stat = 4'h8, W_stat = 4'h8;
  logic          count_clr = 1'b0;
  logic          F_stall, D_stall, D_bubble, E_bubble, W_stall, set_cc, halted;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, bubble_cnt, mispred_cnt;

  pipe_hazard_unit #(.REG_W(4), .STAT_W(4), .CNT_W(CW), .LU_STALL(LU), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat), .count_clr(count_clr),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .W_stall(W_stall), .set_cc(set_cc), .halted(halted), .state(state),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: halted flag, number of forced stall cycles still owed, counters.
  bit m_halted = 1'b0;
  int m_left   = 0;
  int m_stall  = 0, m_bub = 0, m_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  // Apply one cycle of inputs after the falling edge, check everything the
  // DUT shows for that cycle, then advance the model across the next edge.
  task automatic drive(input logic r, input logic [3:0] di, input logic [3:0] ei,
                       input logic [3:0] mi, input logic [3:0] sa, input logic [3:0] sb,
                       input logic [3:0] dm, input logic cnd, input logic [3:0] ms,
                       input logic [3:0] ws, input logic clr);
    bit f, d, db, eb, w, h, cc, exc, mis, lu, ret, mis_ev;
    int st;
    @(negedge clk);
    rst = r; D_icode = di; E_icode = ei; M_icode = mi; d_srcA = sa; d_srcB = sb;
    E_dstM = dm; e_cnd = cnd; m_stat = ms; W_stat = ws; count_clr = clr;
    #1;
    if (r) begin
      m_halted = 1'b0; m_left = 0; m_stall = 0; m_bub = 0; m_mis = 0;
      check("ctl_rst", {23'd0, F_stall, D_stall, D_bubble, E_bubble, W_stall, set_cc,
                        halted, state}, 32'd0);
      check("cnt_rst", {20'd0, stall_cnt, bubble_cnt, mispred_cnt}, 32'd0);
      return;
    end
    exc = (ws != 4'h8);
    mis = (ei == 4'h7) && !cnd;
    lu  = ((ei == 4'h5) || (ei == 4'hB)) && (dm != 4'hF) &&
          (((sa != 4'hF) && (dm == sa)) || ((sb != 4'hF) && (dm == sb)));
    ret = (di == 4'h9) || (ei == 4'h9) || (mi == 4'h9);
    {f, d, db, eb, w, h, mis_ev} = '0;
    cc = !m_halted && (ei != 4'h0) && (ms == 4'h8) && !exc;
    st = m_halted ? 2 : (m_left > 0 ? 1 : 0);
    if (m_halted) begin
      f = 1; d = 1; eb = 1; w = 1; h = 1;
    end else if (exc) begin
      f = 1; d = 1; eb = 1; w = 1;
    end else if (m_left > 0) begin
      f = 1; d = 1; eb = 1;
    end else if (mis) begin
      db = 1; eb = 1; mis_ev = 1;
    end else if (lu) begin
      f = 1; d = 1; eb = 1;
    end else if (ret) begin
      f = 1; db = 1;
    end
    check("ctl", {23'd0, F_stall, D_stall, D_bubble, E_bubble, W_stall, set_cc, halted, state},
          {23'd0, f, d, db, eb, w, cc, h, 2'(st)});
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
    check("mispred_cnt", 32'(mispred_cnt), 32'(m_mis));
    // advance model over the coming edge
    if (clr) begin
      m_stall = 0; m_bub = 0; m_mis = 0;
    end else if (!m_halted) begin
      if (f) m_stall = sat_inc(m_stall);
      if (db || eb) m_bub = sat_inc(m_bub);
      if (mis_ev) m_mis = sat_inc(m_mis);
    end
    if (!m_halted) begin
      if (exc) begin
        m_halted = 1; m_left = 0;
      end else if (m_left > 0) m_left--;
      else if (!mis && lu) m_left = LU - 1;
    end
  endtask

  task automatic idle(input logic clr);
    drive(1'b0, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 4'h8, clr);
  endtask

  function automatic logic [3:0] pick_icode();
    case ($urandom_range(0, 7))
      0: return 4'h0;
      1: return 4'h5;
      2: return 4'hB;
      3: return 4'h7;
      4: return 4'h9;
      5: return 4'h1;
      6: return 4'h2;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [3:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 4'h3;
      1: return 4'hF;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    drive(1'b1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 4'h8, 1'b0);
    drive(1'b1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 4'h8, 1'b0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic r;
      r = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 99) == 0);
      drive(r, pick_icode(), pick_icode(), pick_icode(), pick_reg(), pick_reg(), pick_reg(),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 7)) : 4'h8,
            ($urandom_range(0, 39) == 0) ? 4'($urandom_range(0, 7)) : 4'h8,
            ($urandom_range(0, 11) == 0));
    end

    // load/use with two-cycle stall
    drive(1'b1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 4'h8, 1'b0);
    idle(1'b0);
    drive(1'b0, 4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 4'h8, 4'h8, 1'b0);
    check("lu_c1", {30'd0, F_stall, E_bubble}, 32'h3);
    check("lu_c1_state", 32'(state), 32'd0);
    drive(1'b0, 4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 4'h8, 4'h8, 1'b0);
    check("lu_c2", {30'd0, D_stall, E_bubble}, 32'h3);
    check("lu_c2_state", 32'(state), 32'd1);
    idle(1'b0);
    check("lu_done_state", 32'(state), 32'd0);
    check("lu_done_f", 32'(F_stall), 32'd0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd2);

    // RNONE destination never matches
    idle(1'b1);
    drive(1'b0, 4'h1, 4'hB, 4'h1, 4'h1, 4'hF, 4'hF, 1'b1, 4'h8, 4'h8, 1'b0);
    check("rnone_f", 32'(F_stall), 32'd0);
    idle(1'b0);
    check("rnone_state", 32'(state), 32'd0);
    check("rnone_cnt", 32'(stall_cnt), 32'd0);

    // mispredict outranks ret
    idle(1'b1);
    drive(1'b0, 4'h1, 4'h7, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0, 4'h8, 4'h8, 1'b0);
    check("mis_ctl", {29'd0, D_bubble, E_bubble, F_stall}, 32'h6);
    idle(1'b0);
    check("mis_cnt", 32'(mispred_cnt), 32'd1);
    check("mis_bub_cnt", 32'(bubble_cnt), 32'd1);

    // exception during LU_WAIT, HALT is sticky, reset recovers
    drive(1'b0, 4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 4'h8, 4'h8, 1'b0);
    drive(1'b0, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 4'h4, 1'b0);
    check("exc_lu_w", {30'd0, W_stall, set_cc}, 32'h2);
    idle(1'b0);
    check("halt_state", 32'(state), 32'd2);
    check("halt_flags", {29'd0, halted, set_cc, W_stall}, 32'h5);
    idle(1'b0);
    check("halt_sticky", 32'(state), 32'd2);
    drive(1'b1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 4'h8, 1'b0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    idle(1'b0);
    check("post_rst_run", 32'(state), 32'd0);

    // saturation on 20 ret cycles, then clear coincident with a stall
    for (int i = 0; i < 20; i++)
      drive(1'b0, 4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 4'h8, 1'b0);
    check("sat_stall", 32'(stall_cnt), 32'd15);
    drive(1'b0, 4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 4'h8, 1'b1);
    idle(1'b0);
    check("clr_stall", 32'(stall_cnt), 32'd0);
    check("clr_bub", 32'(bubble_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter REG_W, default 4, register-ID width.
REQ-002 SHALL have parameter STAT_W, default 4, status width; AOK = 4'b1000 (MSB only set), any other value is an exception.
REQ-003 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 SHALL have parameter LU_STALL, default 1, legal 1..3: load/use stall length in cycles.
REQ-005 SHALL have parameter RNONE, default 4'hF, "no register" ID.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 D_icode, E_icode, M_icode  input  4 each  icodes in the D, E and M stages.
REQ-009 d_srcA, d_srcB  input  REG_W each  decode source registers.
REQ-010 E_dstM  input  REG_W  E-stage memory destination register.
REQ-011 e_cnd  input  1  E-stage condition result.
REQ-012 m_stat, W_stat  input  STAT_W each  M and W stage status.
REQ-013 count_clr  input  1  synchronous clear for all counters.
REQ-014 F_stall, D_stall, D_bubble, E_bubble, W_stall  output  1 each  pipeline register controls.
REQ-015 set_cc  output  1  condition-code write enable.
REQ-016 halted  output  1  high while in HALT.
REQ-017 state  output  2  FSM state: RUN=0, LU_WAIT=1, HALT=2.
REQ-018 stall_cnt, bubble_cnt, mispred_cnt  output  CNT_W each  performance counters.

Function
REQ-019 Three states, RUN, LU_WAIT and HALT, SHALL be implemented; 3 is unreachable and SHALL recover to RUN on the next edge.
REQ-020 Load/use hazard SHALL be: E_icode in {4'h5, 4'hB} and E_dstM != RNONE and (E_dstM == d_srcA or E_dstM == d_srcB), ignoring any source equal to RNONE.
REQ-021 Mispredict SHALL be: E_icode == 4'h7 and e_cnd == 0.
REQ-022 Ret-in-flight SHALL be: 4'h9 in D_icode, E_icode or M_icode.
REQ-023 Exception SHALL be: W_stat != AOK.
REQ-024 RUN priority SHALL be exception > mispredict > load/use > ret; only the highest active condition drives outputs.
REQ-025 RUN exception: next state HALT; the same cycle asserts F_stall, D_stall, E_bubble and W_stall, and set_cc is 0.
REQ-026 RUN mispredict: D_bubble = 1 and E_bubble = 1 for one cycle; mispred_cnt increments; state stays RUN.
REQ-027 RUN load/use: F_stall, D_stall and E_bubble = 1; if LU_STALL > 1, go to LU_WAIT with internal counter = LU_STALL-1, otherwise stay RUN.
REQ-028 LU_WAIT: F_stall, D_stall and E_bubble = 1 every cycle; counter decrements; return to RUN on the edge where counter reaches 0; total stall is exactly LU_STALL cycles.
REQ-029 LU_WAIT: an exception SHALL override and go to HALT with REQ-025 outputs.
REQ-030 RUN ret: F_stall = 1 and D_bubble = 1.
REQ-031 HALT SHALL be sticky until rst: F_stall, D_stall, E_bubble, W_stall and halted = 1; D_bubble = 0; set_cc = 0.
REQ-032 set_cc SHALL be 0 when E_icode == 4'h0, m_stat != AOK, W_stat != AOK, in HALT, or while rst is high; otherwise 1.
REQ-033 stall_cnt SHALL increment on every cycle with F_stall = 1 outside HALT.
REQ-034 bubble_cnt SHALL increment on every cycle with D_bubble or E_bubble = 1 outside HALT; one increment per cycle, even if both are high.
REQ-035 All counters SHALL saturate at all-ones and never wrap.
REQ-036 count_clr SHALL zero all counters on the next edge and win over a same-cycle increment.
REQ-037 Control outputs SHALL be combinational from state and inputs; state and counters SHALL be registered.

Reset
REQ-038 rst SHALL immediately force state = RUN, the LU counter to 0 and all counters to 0, including mid-LU_WAIT and in HALT.
REQ-039 While rst is high, all stall and bubble outputs, halted and set_cc SHALL be 0.
REQ-040 The first edge after rst deasserts SHALL evaluate in RUN.

Verification
REQ-041 LU_STALL=2, E_icode=5, E_dstM=3, d_srcA=3 -> F_stall/D_stall/E_bubble high 2 cycles, state 0->1->0, stall_cnt=2.
REQ-042 E_icode=B, E_dstM=F, d_srcB=F -> no stall, state stays RUN, counters unchanged.
REQ-043 E_icode=7, e_cnd=0, plus M_icode=9 in the same cycle -> D_bubble=E_bubble=1, F_stall=0, mispred_cnt=1, bubble_cnt=1.
REQ-044 W_stat=4'b0100 during LU_WAIT -> HALT next edge, halted=1, set_cc=0, W_stall=1; stays HALT after W_stat returns to AOK; rst returns to RUN with counters 0.
REQ-045 CNT_W=4, 20 ret cycles -> stall_cnt holds at 15; count_clr coincident with a stall -> stall_cnt=0.
